// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box table and GF(2^8) round helpers.
// State layout: st[col][row], byte s0,0 at the MSB, matching the FIPS byte stream.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [7:0]              byte_t;
    typedef logic [31:0]             word_t;
    typedef logic [0:3][0:3][7:0]    state_t;
    typedef logic [0:3][31:0]        rkey_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = s[2'(c + r)][r];
        return o;
    endfunction

    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            o[c] = mix_column(s[c]);
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out, no state.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock, 10 cycles accept->out_valid.
// Accepts only in IDLE; result holds in DONE until out_ready.
module aes_encrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    fsm_e       fsm_q;
    state_t     state_q, state_d;
    rkey_t      rkey_q, rkey_d;
    byte_t      rcon_q;
    logic [3:0] round_cnt_q;
    logic       in_ready_q, out_valid_q;

    byte_t      sb_b [16];
    byte_t      kw_b [4];
    state_t     sb_s, sr_s, mc_s;
    word_t      rot_w, sub_w;

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.byte_i(state_q[i / 4][i % 4]), .byte_o(sb_b[i]));
    end

    assign rot_w = rot_word(rkey_q[3]);

    for (genvar j = 0; j < 4; j++) begin : g_subword
        aes_sbox u_sbox (.byte_i(rot_w[31 - 8 * j -: 8]), .byte_o(kw_b[j]));
    end

    always_comb begin
        sb_s = '0;
        for (int i = 0; i < 16; i++)
            sb_s[i / 4][i % 4] = sb_b[i];
        sr_s  = shift_rows(sb_s);
        mc_s  = mix_columns(sr_s);
        sub_w = {kw_b[0], kw_b[1], kw_b[2], kw_b[3]};

        rkey_d    = '0;
        rkey_d[0] = rkey_q[0] ^ sub_w ^ {rcon_q, 24'h0};
        rkey_d[1] = rkey_q[1] ^ rkey_d[0];
        rkey_d[2] = rkey_q[2] ^ rkey_d[1];
        rkey_d[3] = rkey_q[3] ^ rkey_d[2];

        // The final round skips MixColumns.
        state_d = ((round_cnt_q == 4'(NR)) ? sr_s : mc_s) ^ rkey_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            rcon_q      <= 8'h01;
            round_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= plaintext ^ key;
                        rkey_q      <= key;
                        rcon_q      <= 8'h01;
                        round_cnt_q <= 4'd1;
                        in_ready_q  <= 1'b0;
                        fsm_q       <= ROUND;
                    end
                end
                ROUND: begin
                    state_q     <= state_d;
                    rkey_q      <= rkey_d;
                    rcon_q      <= xtime(rcon_q);
                    round_cnt_q <= round_cnt_q + 4'd1;
                    if (round_cnt_q == 4'(NR)) begin
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core using FIPS-197 vectors and a ciphertext scoreboard.
module tb_aes_encrypt_core;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid;
    logic [127:0] ciphertext;

    logic [127:0] sb [$];
    logic [127:0] pts [2];
    logic [127:0] keys [2];
    logic [127:0] cts [2];
    int           n_vec = 0;
    int           n_err = 0;

    aes_encrypt_core dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one block at a negedge; returns at the negedge after the accept edge.
    task automatic send(input string tag, input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] exp);
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int           cyc;
        logic [127:0] exp;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
        if (exp_lat >= 0)
            check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "_ct"}, ciphertext, exp);
    endtask

    initial begin
        int nacc, nout, acc_t[2];
        bit pend;
        logic [127:0] exp;

        pts[0] = PB; keys[0] = KB; cts[0] = CB;
        pts[1] = PC; keys[1] = KC; cts[1] = CC;

        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // App. B, then 5 cycles of held backpressure.
        send("appB", PB, KB, CB);
        collect("appB", 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_ct", ciphertext, CB);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // App. C.1 with out_ready already high: single-cycle out_valid.
        send("appC", PC, KC, CC);
        collect("appC", 10);
        @(negedge clk);
        check("appC_one_cycle", 128'(out_valid), 128'd0);

        // Foreign block offered during round 4 must be ignored.
        send("busy", PB, KB, CB);
        repeat (3) @(negedge clk);
        check("busy_in_ready", 128'(in_ready), 128'd0);
        plaintext = PC;
        key       = KC;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        collect("busy", -1);
        repeat (12) @(negedge clk);
        check("busy_no_extra", 128'(out_valid), 128'd0);

        // Asynchronous reset during round 6, then a fresh block.
        send("rst_mid", PB, KB, CB);
        repeat (5) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rstmid_in_ready", 128'(in_ready), 128'd1);
        check("rstmid_out_valid", 128'(out_valid), 128'd0);
        check("rstmid_ct", ciphertext, 128'd0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        send("after_rst", PC, KC, CC);
        collect("after_rst", 10);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        plaintext = PB;
        key       = KB;
        in_valid  = 1'b1;
        nacc = 0; nout = 0; pend = 0;
        acc_t[0] = 0; acc_t[1] = 0;
        for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
            if (pend) begin
                pend = 0;
                if (nacc < 2) begin
                    plaintext = pts[nacc];
                    key       = keys[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                nout++;
                exp = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("b2b_ct", ciphertext, exp);
            end
            if (in_valid && in_ready && nacc < 2) begin
                acc_t[nacc] = cyc;
                sb.push_back(cts[nacc]);
                nacc++;
                pend = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_outputs", 128'(nout), 128'd2);
        check("b2b_interval", 128'(acc_t[1] - acc_t[0]), 128'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
